// File: rtl/alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// alu_result_uart_tx
//
// Purpose:
//   This block sends the 8-bit ALU result to a host terminal over a UART line.
//   When a send request is accepted, it latches the result and transmits a
//   four-character message:
//     - two uppercase ASCII hex digits (high nibble first)
//     - CR (0x0D)
//     - LF (0x0A)
//   Each character uses UART framing: a start bit (0), 8 data bits sent LSB
//   first, and a stop bit (1).
//
// Optional feature:
//   Define ALU_TX_PARITY_EN to add an even-parity bit between data bit 7 and
//   the stop bit. This makes each frame 11 bits. When the macro is not defined,
//   there is no parity state and each frame is 10 bits (8N1).
//
// Parameters:
//   CLK_HZ : input clock frequency in Hz
//   BAUD   : line rate. DIV = CLK_HZ / BAUD, rounded down, and must be >= 2.
//
// Ports:
//   clk    : clock; all logic runs on its rising edge
//   rst    : synchronous, active-high reset; aborts any message in progress
//   result : ALU result; sampled only when a request is accepted
//   send   : transmit request, sampled as a level each cycle;
//            ignored while busy
//   busy   : high while a message is in progress
//   done   : one-cycle pulse in the cycle after the final stop bit
//   tx     : UART output line; idle high
// -----------------------------------------------------------------------------
module alu_result_uart_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Stop elaboration if the divisor is too small. With DIV < 2, a bit
    // period cannot be held for DIV cycles as required.
    generate
        if (DIV < 2) begin : g_div_check
            $error("alu_result_uart_tx: CLK_HZ / BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ALU_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       char_idx_q, char_idx_d;
    logic [7:0]       hold_q, hold_d;
    logic             done_q, done_d;

    logic             baud_tick;
    logic [7:0]       char_cur;

    // Convert one nibble to an uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Select the character being sent. It comes only from the latched copy
    // in hold_q, so changes on 'result' during a message do not matter.
    always_comb begin
        char_cur = 8'h0A;
        case (char_idx_q)
            2'd0:    char_cur = hex_ascii(hold_q[7:4]);
            2'd1:    char_cur = hex_ascii(hold_q[3:0]);
            2'd2:    char_cur = 8'h0D;
            default: char_cur = 8'h0A;
        endcase
    end

    // baud_tick marks the last cycle of the current bit period.
    assign baud_tick = (baud_cnt_q == LAST_CNT);

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        hold_d     = hold_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            baud_cnt_d = '0;
            if (send) begin
                hold_d     = result;
                char_idx_d = 2'd0;
                bit_idx_d  = 3'd0;
                state_d    = START;
            end
        end else begin
            baud_cnt_d = baud_tick ? '0 : (baud_cnt_q + CNT_ONE);
            if (baud_tick) begin
                case (state_q)
                    START: begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                    DATA: begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = 3'd0;
`ifdef ALU_TX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
`ifdef ALU_TX_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                    end
`endif
                    STOP: begin
                        if (char_idx_q == 2'd3) begin
                            char_idx_d = 2'd0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            char_idx_d = char_idx_q + 2'd1;
                            state_d    = START;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Drive the line directly from registered state, so it does not depend
    // on the inputs in the same cycle.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = char_cur[bit_idx_q];
`ifdef ALU_TX_PARITY_EN
            PARITY: tx = ^char_cur;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= 2'd0;
            hold_q     <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_alu_result_uart_tx
//
// Directed testbench for alu_result_uart_tx with CLK_HZ=1000 and BAUD=100,
// giving DIV=10.
//
// How it works:
//   - The bench records tx, busy and done on every falling clock edge into
//     logs.
//   - It then decodes frames from the centre of each bit period and compares
//     the results against hand-computed values.
//
// Input timing:
//   Inputs are driven with blocking assignments on falling edges.
// -----------------------------------------------------------------------------
module tb_alu_result_uart_tx;

    localparam int DIV = 10;
`ifdef ALU_TX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif
    localparam int MSG = 4 * FR * DIV;
    localparam int LOG_N = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] result;
    logic       send;
    logic       busy;
    logic       done;
    logic       tx;

    int errors = 0;
    int checks = 0;

    logic tx_log   [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    logic done_log [0:LOG_N-1];

    always #5 clk = ~clk;

    alu_result_uart_tx #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .result(result),
        .send  (send),
        .busy  (busy),
        .done  (done),
        .tx    (tx)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Enter at a falling edge. Pulse send for one cycle and return at the
    // falling edge that should be the first cycle of the start bit.
    task automatic pulse_send(input logic [7:0] v);
        result = v;
        send   = 1'b1;
        @(negedge clk);
        send   = 1'b0;
    endtask

    // Log n cycles, starting with the current falling edge.
    // If poke_from is not -1, raise send with result=0xFF from index
    // poke_from until index poke_to.
    task automatic capture(input int n, input int poke_from, input int poke_to);
        for (int i = 0; i < n; i++) begin
            tx_log[i]   = tx;
            busy_log[i] = busy;
            done_log[i] = done;
            if (i == poke_from) begin
                send   = 1'b1;
                result = 8'hFF;
            end
            if (i == poke_to) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Decode the data byte of a frame that starts at log index 'base'.
    function automatic logic [7:0] decode(input int base);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) begin
            d[b] = tx_log[base + (b + 1) * DIV + DIV / 2];
        end
        return d;
    endfunction

    // Check a full four-character message that starts at log index 'base'.
    task automatic check_msg(input string tag, input int base, input logic [7:0] c0, input logic [7:0] c1);
        logic [7:0] exp_c [4];
        logic [7:0] got_c [4];
        int         busy_cnt;
        int         done_cnt;

        exp_c[0] = c0;
        exp_c[1] = c1;
        exp_c[2] = 8'h0D;
        exp_c[3] = 8'h0A;

        for (int c = 0; c < 4; c++) begin
            int fb;
            fb = base + c * FR * DIV;
            got_c[c] = decode(fb);
            check1({tag, "_start"}, tx_log[fb + DIV / 2], 1'b0);
            check8({tag, "_char"}, got_c[c], exp_c[c]);
            check1({tag, "_stop"}, tx_log[fb + (FR - 1) * DIV + DIV / 2], 1'b1);
        end

        busy_cnt = 0;
        done_cnt = 0;
        for (int i = base; i < base + MSG; i++) begin
            if (busy_log[i] === 1'b1) busy_cnt++;
            if (done_log[i] === 1'b1) done_cnt++;
        end

        check_int({tag, "_busy_len"}, busy_cnt, MSG);
        check_int({tag, "_done_early"}, done_cnt, 0);
        check1({tag, "_end_busy"}, busy_log[base + MSG], 1'b0);
        check1({tag, "_end_done"}, done_log[base + MSG], 1'b1);
        check1({tag, "_end_tx"}, tx_log[base + MSG], 1'b1);

        $display("msg %s base=%0d chars=%h %h %h %h", tag, base,
                 got_c[0], got_c[1], got_c[2], got_c[3]);
    endtask

    initial begin
        logic [8:0] fb9;
        int         busy_cnt;
        int         wait_cnt;

        rst    = 1'b1;
        send   = 1'b0;
        result = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check1("rst_tx", tx, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: 0x3C -> "3C\r\n". Expect a single done pulse.
        pulse_send(8'h3C);
        capture(MSG + 10, -1, -1);
        check_msg("m3c", 0, 8'h33, 8'h43);
        check1("m3c_done_once", done_log[MSG + 1], 1'b0);
`ifdef ALU_TX_PARITY_EN
        // 0x33 has four 1 bits and 0x43 has three, so parity is 0 then 1.
        check1("par_33", tx_log[(FR - 2) * DIV + DIV / 2], 1'b0);
        check1("par_43", tx_log[FR * DIV + (FR - 2) * DIV + DIV / 2], 1'b1);
        check1("par_len_last_busy", busy_log[439], 1'b1);
        check1("par_len_done", done_log[440], 1'b1);
`endif

        // Test 2: a send request during a message is ignored.
        // The output must still be "3C\r\n", with no second message.
        pulse_send(8'h3C);
        capture(MSG + 60, 50, 60);
        check_msg("ign", 0, 8'h33, 8'h43);
        busy_cnt = 0;
        for (int i = MSG + 1; i < MSG + 60; i++) begin
            if (busy_log[i] === 1'b1) busy_cnt++;
        end
        check_int("ign_no_second_msg", busy_cnt, 0);

        // Test 3: reset during cycle 125 of a message.
        pulse_send(8'h55);
        capture(125, -1, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("abort_tx", tx, 1'b1);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        repeat (3) @(negedge clk);
        check1("abort_still_idle", busy, 1'b0);

        // Test 4: a fresh message after the abort, with result 0xA5.
        // Also check character 0 bit by bit.
        pulse_send(8'hA5);
        capture(MSG + 10, -1, -1);
        check_msg("ma5", 0, 8'h41, 8'h35);

        // Start bit, then 0x41 sent LSB first: 1,0,0,0,0,0,1,0.
        fb9 = {8'h41, 1'b0};
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < DIV; j++) begin
                check1("ma5_bit_hold", tx_log[k * DIV + j], fb9[k]);
            end
        end
        for (int j = 0; j < DIV; j++) begin
            check1("ma5_stop_hold", tx_log[(FR - 1) * DIV + j], 1'b1);
        end

        // Test 5: hold send high with result 0x00.
        // Messages repeat, and each done cycle is followed by a start bit.
        result = 8'h00;
        send   = 1'b1;
        @(negedge clk);
        capture(2 * MSG + 11, -1, -1);
        check_msg("rep0", 0, 8'h30, 8'h30);
        check1("rep0_next_start_tx", tx_log[MSG + 1], 1'b0);
        check1("rep0_next_start_busy", busy_log[MSG + 1], 1'b1);
        check_msg("rep1", MSG + 1, 8'h30, 8'h30);
        check1("rep1_next_start_tx", tx_log[2 * MSG + 2], 1'b0);
        send = 1'b0;

        // Let the third message finish. The wait is bounded.
        wait_cnt = 0;
        while (busy !== 1'b0 && wait_cnt < 2 * MSG) begin
            @(negedge clk);
            wait_cnt++;
        end
        check1("rep_drain_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_uart_tx.md
# alu_result_uart_tx

Serial transmitter for the ALU result bus. It captures the 8-bit ALU core output `Y` on a `send` request and transmits it as two uppercase ASCII hex characters followed by CR LF, using 8N1 UART framing on a single `tx` line. It sits on the output side of the ALU core, beside the LED mapping, and carries the same result to a host terminal.

## Interface
- `CLK_HZ`, default 50000000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate. Divisor `DIV = CLK_HZ / BAUD`, integer, rounded down. `DIV >= 2` is required; an elaboration-time check fails the build otherwise.

- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `result`, input, 8: ALU result (`Y`), unsigned; sampled only at accept.
- `send`, input, 1: transmit request, level-sampled each cycle.
- `busy`, output, 1: high while a message is in progress.
- `done`, output, 1: one-cycle pulse at message completion.
- `tx`, output, 1: UART line, idle high.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- Accept: `send`=1 while `busy`=0 latches `result` into a holding register and starts the message. `send` while `busy`=1 is ignored and is not queued.
- Message: 4 characters, index 0..3.
  - 0: hex of `result[7:4]`.
  - 1: hex of `result[3:0]`.
  - 2: 0x0D.
  - 3: 0x0A.
- Hex mapping: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46 (uppercase).
- Character frame: start bit 0, 8 data bits LSB first, optional parity bit (see Configuration), stop bit 1.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA (8 bits) -> PARITY if enabled, else STOP.
  - PARITY -> STOP.
  - STOP -> START for the next character if index < 3.
  - STOP -> IDLE after index 3, pulsing `done`.
- Each bit state holds `tx` for exactly `DIV` cycles. A baud counter counts 0..DIV-1 and advances the state or bit on DIV-1.
- A change on `result` during a message has no effect. Only the latched value is sent.
- Reset mid-message aborts immediately. The next cycle shows the reset values, and the partial character is not completed.

## Timing
- Accept in cycle N: `busy`=1 and `tx`=0 (start bit) from cycle N+1.
- Bit k of a character starts `k*DIV` cycles after that character's start bit begins.
- Characters are back-to-back with no idle gap; the next start bit follows the last stop bit cycle.
- Message length: `4*10*DIV` cycles without parity, `4*11*DIV` with parity.
- End of message, in the cycle after the final stop bit's last cycle:
  - `busy`=0, `done`=1 for exactly one cycle, `tx`=1.
- Back-to-back: `send`=1 in the `done` cycle is accepted, because `busy` is already 0. The new start bit appears in the following cycle.

## Configuration
- `ALU_TX_PARITY_EN`
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit, giving an 11-bit frame.
  - Undefined: no parity state exists, giving a 10-bit 8N1 frame.
  - Either way, the ports are unchanged.

## Test plan
Bench parameters: `CLK_HZ`=1000, `BAUD`=100, so `DIV`=10.
- `result`=0x3C, 1-cycle `send` -> `tx` decodes to 0x33, 0x43, 0x0D, 0x0A. `busy` is high for 400 cycles, then `done` pulses once.
- `result`=0xA5 -> first two characters are 0x41, 0x35. Bit-level check on character 0: start 0, then 1,0,0,0,0,0,1,0, then stop 1, each bit held 10 cycles.
- Accept 0x3C; at cycle 50 raise `send` with `result`=0xFF -> ignored. Output still decodes to "3C\r\n", and no second message follows.
- Reset asserted at cycle 125 of a message -> next cycle `tx`=1, `busy`=0, `done`=0. A fresh `send` afterwards sends a complete, correct message.
- `send` held high continuously with `result`=0x00 -> messages "00\r\n" repeat with no idle gap. Each `done` pulse is followed by a start bit on the next cycle.
- With `ALU_TX_PARITY_EN`, `result`=0x3C -> the parity bit of 0x33 is 0 and of 0x43 is 1. Message length is 440 cycles.
